// File: rtl/alu_operand_stage.sv
// Decode / operand-fetch stage ahead of the ALU: decodes one instruction per handshake,
// reads the register file (with writeback bypass) and registers the ALU operands.
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 14,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_decode,
    output logic [DATA_W-1:0] rda,
    output logic [DATA_W-1:0] rdx,
    output logic [REG_AW-1:0] rd_addr,
    output logic              rd_we,
    output logic              illegal,
    output logic [CNT_W-1:0]  issue_count
);
    localparam int NREG = 2**REG_AW;

    typedef struct packed {
        logic [3:0]        alu_decode;
        logic [DATA_W-1:0] rda;
        logic [DATA_W-1:0] rdx;
        logic [REG_AW-1:0] rd_addr;
        logic              rd_we;
        logic              illegal;
    } op_t;

    op_t               dec, op_q;
    logic [DATA_W-1:0] regs [NREG];
    logic [3:0]        op, aluop;
    logic [REG_AW-1:0] rd, rs_x, rs_a;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] x_val, a_val, imm_ext;
    logic              accept, is_r, is_i, legal;

    assign op    = instr[31:28];
    assign aluop = instr[27:24];
    assign rd    = instr[19 +: REG_AW];
    assign rs_x  = instr[14 +: REG_AW];
    assign rs_a  = instr[9 +: REG_AW];
    assign imm   = instr[IMM_W-1:0];

    assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign is_r    = (op == 4'h0);
    assign is_i    = (op == 4'h1);
    assign legal   = (is_r || is_i) && (aluop <= 4'd8);

    // Writeback in the same cycle must win over the stale array value.
    assign x_val = (rs_x == '0) ? '0 : (wb_en && wb_addr == rs_x) ? wb_data : regs[rs_x];
    assign a_val = (rs_a == '0) ? '0 : (wb_en && wb_addr == rs_a) ? wb_data : regs[rs_a];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec         = '0;
        dec.rd_addr = rd;
        dec.rdx     = x_val;
        dec.rda     = is_i ? imm_ext : a_val;
        if (legal) begin
            dec.alu_decode = aluop;
            dec.rd_we      = 1'b1;
        end else if (op != 4'hF) begin
            dec.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            op_q        <= '0;
            issue_count <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            op_q        <= dec;
            issue_count <= issue_count + 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // R0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign alu_decode = op_q.alu_decode;
    assign rda        = op_q.rda;
    assign rdx        = op_q.rdx;
    assign rd_addr    = op_q.rd_addr;
    assign rd_we      = op_q.rd_we;
    assign illegal    = op_q.illegal;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed plus randomized bench for alu_operand_stage against a field-level reference model.
module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, wb_en, out_valid, out_ready, rd_we, illegal;
    logic [31:0] instr, wb_data, rda, rdx;
    logic [4:0]  wb_addr, rd_addr;
    logic [3:0]  alu_decode;
    logic [15:0] issue_count;

    int checks = 0;
    int failures = 0;

    logic        m_valid, m_we, m_ill, m_rst;
    logic [3:0]  m_dec;
    logic [31:0] m_rda, m_rdx;
    logic [4:0]  m_rd;
    logic [15:0] m_cnt;
    logic [31:0] m_regs [32];

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .alu_decode(alu_decode), .rda(rda), .rdx(rdx),
        .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal), .issue_count(issue_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] mk_r(input logic [3:0] op, input logic [3:0] aluop,
                                         input logic [4:0] rd, input logic [4:0] rsx,
                                         input logic [4:0] rsa);
        return {op, aluop, rd, rsx, rsa, 9'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [3:0] aluop, input logic [4:0] rd,
                                         input logic [4:0] rsx, input logic [13:0] imm);
        return {4'h1, aluop, rd, rsx, imm};
    endfunction

    // One clock: predict from current inputs, cross the edge, compare.
    task automatic tick();
        int op, aluop, imm;
        logic acc;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        m_rst = reset;
        if (reset) begin
            m_valid = 0; m_we = 0; m_ill = 0; m_dec = 0; m_rda = 0; m_rdx = 0; m_rd = 0; m_cnt = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (acc) begin
                op    = int'(instr[31:28]);
                aluop = int'(instr[27:24]);
                m_rd  = instr[23:19];
                m_we  = (op == 0 || op == 1) && aluop <= 8;
                m_ill = !m_we && op != 15;
                m_dec = m_we ? instr[27:24] : 4'd0;
                m_rdx = mread(instr[18:14]);
                if (op == 1) begin
                    imm = int'(instr[13:0]);
                    if (imm >= 8192) imm -= 16384;
                    m_rda = 32'(imm);
                end else begin
                    m_rda = mread(instr[13:9]);
                end
                m_valid = 1;
                m_cnt   = m_cnt + 16'd1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("issue_count", 32'(issue_count), 32'(m_cnt));
        if (m_valid || m_rst) begin
            chk("alu_decode", 32'(alu_decode), 32'(m_dec));
            chk("rd_we", 32'(rd_we), 32'(m_we));
            chk("illegal", 32'(illegal), 32'(m_ill));
            chk("rd_addr", 32'(rd_addr), 32'(m_rd));
        end
        if ((m_valid && m_we) || m_rst) begin
            chk("rda", rda, m_rda);
            chk("rdx", rdx, m_rdx);
        end
    endtask

    initial begin
        reset = 1; in_valid = 0; instr = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
        m_valid = 0; m_cnt = 0;
        tick(); tick();
        reset = 0;

        // 1: preload R3/R4, R-type op
        wb_en = 1; wb_addr = 3; wb_data = 5; tick();
        wb_addr = 4; wb_data = 7; tick();
        wb_en = 0;
        in_valid = 1; instr = mk_r(4'h0, 4'd2, 5'd5, 5'd3, 5'd4); tick();
        in_valid = 0;
        chk("t1_rdx", rdx, 32'd5);
        chk("t1_rda", rda, 32'd7);
        chk("t1_dec", 32'(alu_decode), 32'd2);
        chk("t1_cnt", 32'(issue_count), 32'd1);

        // 2: I-type with all-ones immediate
        in_valid = 1; instr = mk_i(4'd6, 5'd6, 5'd3, 14'h3FFF); tick();
        chk("t2_rda", rda, 32'hFFFF_FFFF);
        chk("t2_rdx", rdx, 32'd5);

        // 3: stall two cycles, then release
        out_ready = 0; instr = mk_r(4'h0, 4'd1, 5'd7, 5'd4, 5'd3); tick(); tick();
        chk("t3_frozen_dec", 32'(alu_decode), 32'd6);
        chk("t3_frozen_cnt", 32'(issue_count), 32'd2);
        out_ready = 1; tick();
        in_valid = 0;
        chk("t3_next_dec", 32'(alu_decode), 32'd1);
        chk("t3_next_rdx", rdx, 32'd7);

        // 4: same-cycle writeback bypass, then R0 write ignored
        in_valid = 1; instr = mk_r(4'h0, 4'd0, 5'd8, 5'd3, 5'd0);
        wb_en = 1; wb_addr = 3; wb_data = 32'hA5; tick();
        chk("t4_bypass", rdx, 32'hA5);
        in_valid = 0; wb_addr = 0; wb_data = 1; tick();
        wb_en = 0; in_valid = 1; instr = mk_r(4'h0, 4'd0, 5'd9, 5'd0, 5'd0); tick();
        chk("t4_r0", rdx, 32'd0);

        // 5: illegal / boundary aluop / NOP
        instr = mk_r(4'h2, 4'd1, 5'd1, 5'd1, 5'd1); tick();
        chk("t5_op2_ill", 32'(illegal), 32'd1);
        instr = mk_r(4'h0, 4'd9, 5'd1, 5'd1, 5'd1); tick();
        chk("t5_alu9_ill", 32'(illegal), 32'd1);
        instr = mk_r(4'h0, 4'd8, 5'd1, 5'd3, 5'd4); tick();
        chk("t5_alu8_dec", 32'(alu_decode), 32'd8);
        instr = mk_r(4'hF, 4'd3, 5'd1, 5'd1, 5'd1); tick();
        chk("t5_nop_ill", 32'(illegal), 32'd0);
        chk("t5_nop_we", 32'(rd_we), 32'd0);

        // 6: reset during stall with accept and writeback pending
        out_ready = 0; instr = mk_r(4'h0, 4'd2, 5'd2, 5'd3, 5'd4); tick();
        reset = 1; wb_en = 1; wb_addr = 10; wb_data = 32'h1234; tick();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_cnt", 32'(issue_count), 32'd0);
        reset = 0; wb_en = 0; out_ready = 1; instr = mk_r(4'h0, 4'd0, 5'd1, 5'd10, 5'd10); tick();
        chk("t6_r10", rdx, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            int cls;
            reset     = ($urandom % 150) == 0;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            wb_en     = ($urandom % 2) != 0;
            wb_addr   = 5'($urandom);
            wb_data   = $urandom;
            cls       = int'($urandom % 8);
            instr     = $urandom;
            if (cls < 3)       instr[31:28] = 4'h0;
            else if (cls < 6)  instr[31:28] = 4'h1;
            else if (cls == 6) instr[31:28] = 4'hF;
            instr[27:24] = 4'($urandom_range(0, 10));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
